// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: multi-channel, runtime-programmable tick generator.
//   Each channel emits a one-clk-wide strobe every div[i] enabled clk cycles.
//   The strobes are clock enables for time counters and display logic.
//   They are never used as clocks.
//
// Optional feature macro: PULSE_GEN_SQUARE_OUT_EN
//   When defined, the sq_out port is present. Each sq_out[i] toggles on every pulse[i].
//   This gives a 50% square wave with a period of 2*div[i] enabled cycles.
//
// Ports:
//   clk      in   system clock, all logic on posedge
//   rst      in   synchronous reset, active-high
//   en       in   per-channel count enable
//   sync     in   one-cycle strobe, clears every channel's phase
//   cfg_wr   in   one-cycle divisor write strobe
//   cfg_ch   in   channel index for cfg_wr
//   cfg_div  in   new divisor for cfg_ch
//   cfg_err  out  one-cycle strobe: cfg_wr rejected (bad channel or zero divisor)
//   pulse    out  per-channel tick strobe, registered
//   sq_out   out  per-channel square wave (macro only)
module pulse_gen_multi #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned DIV_W    = 32,
  parameter int unsigned CH_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pulse
`ifdef PULSE_GEN_SQUARE_OUT_EN
  ,
  output logic [NUM_CH-1:0] sq_out
`endif
);

  localparam logic [DIV_W-1:0] DivRst = DIV_W'(CLK_FREQ);

  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_d [NUM_CH];
  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [DIV_W-1:0]  div_d [NUM_CH];
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic              cfg_err_q, cfg_err_d;
  logic              wr_ok;
  logic [NUM_CH-1:0] wr_hit;
`ifdef PULSE_GEN_SQUARE_OUT_EN
  logic [NUM_CH-1:0] sq_q, sq_d;
`endif

  // A rejected write must leave every channel untouched.
  assign wr_ok = cfg_wr && (32'(cfg_ch) < NUM_CH) && (cfg_div != '0);

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_ok && (cfg_ch == CH_W'(i));
    end
  end

  always_comb begin
    cfg_err_d = cfg_wr && !wr_ok;
    pulse_d   = '0;
`ifdef PULSE_GEN_SQUARE_OUT_EN
    sq_d      = sq_q;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      div_d[i] = div_q[i];
      if (wr_hit[i]) begin
        // A new divisor restarts the phase, so no stray pulse comes from the old count.
        div_d[i] = cfg_div;
        cnt_d[i] = '0;
`ifdef PULSE_GEN_SQUARE_OUT_EN
        sq_d[i]  = 1'b0;
`endif
      end else if (sync) begin
        cnt_d[i] = '0;
`ifdef PULSE_GEN_SQUARE_OUT_EN
        sq_d[i]  = 1'b0;
`endif
      end else if (en[i]) begin
        // cnt never exceeds div-1, so this compare is the only wrap point.
        if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
          cnt_d[i]   = '0;
          pulse_d[i] = 1'b1;
`ifdef PULSE_GEN_SQUARE_OUT_EN
          sq_d[i]    = ~sq_q[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DivRst;
      end
      pulse_q   <= '0;
      cfg_err_q <= 1'b0;
`ifdef PULSE_GEN_SQUARE_OUT_EN
      sq_q      <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pulse_q   <= pulse_d;
      cfg_err_q <= cfg_err_d;
`ifdef PULSE_GEN_SQUARE_OUT_EN
      sq_q      <= sq_d;
`endif
    end
  end

  assign pulse   = pulse_q;
  assign cfg_err = cfg_err_q;
`ifdef PULSE_GEN_SQUARE_OUT_EN
  assign sq_out  = sq_q;
`endif

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Testbench for pulse_gen_multi.
// The reference model counts the enabled edges seen since each channel's last clear.
// A pulse is due when that count is a multiple of the divisor.
// The square wave is the parity of (count / divisor).
// Directed scenarios add literal expectations at hand-computed cycles.
module tb_pulse_gen_multi;

  localparam int unsigned CLK_FREQ = 10;
  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned DIV_W    = 32;
  localparam int unsigned CH_W     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NUM_CH-1:0] en = '0;
  logic              sync = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              cfg_err;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] sq_out_w;

  pulse_gen_multi #(
    .CLK_FREQ(CLK_FREQ),
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .CH_W    (CH_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .cfg_wr (cfg_wr),
    .cfg_ch (cfg_ch),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .pulse  (pulse)
`ifdef PULSE_GEN_SQUARE_OUT_EN
    ,
    .sq_out (sq_out_w)
`endif
  );

`ifndef PULSE_GEN_SQUARE_OUT_EN
  assign sq_out_w = '0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rel    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s rel_cycle %0d: got %0h expected %0h", name, rel, act, exp);
    end
  endtask

  // Reference model
  bit                model_ok = 1'b0;
  longint            el  [NUM_CH];
  longint            md  [NUM_CH];
  logic [NUM_CH-1:0] exp_pulse;
  logic [NUM_CH-1:0] exp_sq;
  logic              exp_err;

  function automatic bit write_valid(input logic wr, input logic [CH_W-1:0] ch,
                                     input logic [DIV_W-1:0] dv);
    return wr && (int'(ch) < int'(NUM_CH)) && (dv != 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        el[ch] <= 0;
        md[ch] <= longint'(CLK_FREQ);
      end
      exp_pulse <= '0;
      exp_sq    <= '0;
      exp_err   <= 1'b0;
      model_ok  <= 1'b1;
    end else begin
      exp_err <= cfg_wr && !write_valid(cfg_wr, cfg_ch, cfg_div);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (write_valid(cfg_wr, cfg_ch, cfg_div) && int'(cfg_ch) == ch) begin
          md[ch]        <= longint'(cfg_div);
          el[ch]        <= 0;
          exp_pulse[ch] <= 1'b0;
          exp_sq[ch]    <= 1'b0;
        end else if (sync) begin
          el[ch]        <= 0;
          exp_pulse[ch] <= 1'b0;
          exp_sq[ch]    <= 1'b0;
        end else if (!en[ch]) begin
          exp_pulse[ch] <= 1'b0;
        end else begin
          el[ch]        <= el[ch] + 1;
          exp_pulse[ch] <= ((el[ch] + 1) % md[ch]) == 0;
          exp_sq[ch]    <= (((el[ch] + 1) / md[ch]) % 2) == 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_pulse", 32'(pulse), 32'(exp_pulse));
      check("model_cfg_err", 32'(cfg_err), 32'(exp_err));
`ifdef PULSE_GEN_SQUARE_OUT_EN
      check("model_sq_out", 32'(sq_out_w), 32'(exp_sq));
`endif
    end
  end

  // Stimulus helpers: inputs change at negedge, rel counts posedges since reset release.
  task automatic tick();
    @(negedge clk);
    rel++;
  endtask

  task automatic run_to(input int n);
    while (rel < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rel = 0;
  endtask

  task automatic wr(input int ch, input int dv);
    cfg_wr  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = DIV_W'(dv);
    tick();
    cfg_wr  = 1'b0;
  endtask

  initial begin
    // 1: default divisor of 10 on all channels
    do_reset();
    check("reset_pulse", 32'(pulse), 32'h0);
    check("reset_err", 32'(cfg_err), 32'h0);
    en = 3'b111;
    run_to(9);  check("t1_c9", 32'(pulse), 32'h0);
    run_to(10); check("t1_c10", 32'(pulse), 32'h7);
    run_to(11); check("t1_c11", 32'(pulse), 32'h0);
    run_to(20); check("t1_c20", 32'(pulse), 32'h7);
    run_to(30); check("t1_c30", 32'(pulse), 32'h7);

    // 2: ch1 reprogrammed to 4 at cycle 5
    do_reset();
    en = 3'b111;
    run_to(4);
    wr(1, 4);
    run_to(9);  check("t2_c9", 32'(pulse), 32'h2);
    run_to(10); check("t2_c10", 32'(pulse), 32'h5);
    run_to(13); check("t2_c13", 32'(pulse), 32'h2);
    run_to(20); check("t2_c20", 32'(pulse), 32'h5);
    run_to(21); check("t2_c21", 32'(pulse), 32'h2);

    // 3: en[0] low for three cycles stretches one period to 13
    do_reset();
    en = 3'b111;
    run_to(14);
    en = 3'b110;
    run_to(17);
    en = 3'b111;
    run_to(20); check("t3_c20", 32'(pulse), 32'h6);
    run_to(23); check("t3_c23", 32'(pulse), 32'h1);
    run_to(30); check("t3_c30", 32'(pulse), 32'h6);
    run_to(33); check("t3_c33", 32'(pulse), 32'h1);

    // 4: sync with divisors 10/4/3, then sync together with a write
    do_reset();
    en = 3'b111;
    wr(1, 4);
    wr(2, 3);
    run_to(6);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("t4_c7", 32'(pulse), 32'h0);
    run_to(10); check("t4_c10", 32'(pulse), 32'h4);
    run_to(11); check("t4_c11", 32'(pulse), 32'h2);
    run_to(17); check("t4_c17", 32'(pulse), 32'h1);
    run_to(20);
    sync    = 1'b1;
    cfg_wr  = 1'b1;
    cfg_ch  = 2'd2;
    cfg_div = 32'd5;
    tick();
    sync    = 1'b0;
    cfg_wr  = 1'b0;
    check("t4_c21", 32'(pulse), 32'h0);
    run_to(25); check("t4_c25", 32'(pulse), 32'h2);
    run_to(26); check("t4_c26", 32'(pulse), 32'h4);
    run_to(31); check("t4_c31", 32'(pulse), 32'h5);

    // 5: rejected writes, then div=1 gives a continuous strobe
    do_reset();
    en = 3'b111;
    run_to(2);
    wr(3, 7);
    check("t5_err_ch", 32'(cfg_err), 32'h1);
    tick();
    check("t5_err_drop", 32'(cfg_err), 32'h0);
    wr(0, 0);
    check("t5_err_div0", 32'(cfg_err), 32'h1);
    run_to(10); check("t5_c10", 32'(pulse), 32'h7);
    run_to(12);
    wr(2, 1);
    check("t5_c13", 32'(pulse), 32'h0);
    tick(); check("t5_c14", 32'(pulse), 32'h4);
    tick(); check("t5_c15", 32'(pulse), 32'h4);
    run_to(20); check("t5_c20", 32'(pulse), 32'h7);

    // 6: square wave with div=4, then reset mid-run restores divisor 10
    do_reset();
    en = 3'b111;
    wr(0, 4);
    run_to(4);  check("t6_c4_sq", 32'(sq_out_w[0]), 32'h0);
    run_to(5);  check("t6_c5_sq", 32'(sq_out_w[0]), 32'(1'b1 && sq_enabled()));
    run_to(8);  check("t6_c8_sq", 32'(sq_out_w[0]), 32'(1'b1 && sq_enabled()));
    run_to(9);  check("t6_c9_sq", 32'(sq_out_w[0]), 32'h0);
    check("t6_c9_pulse", 32'(pulse), 32'h1);
    run_to(13); check("t6_c13_sq", 32'(sq_out_w[0]), 32'(1'b1 && sq_enabled()));
    run_to(14);
    rst = 1'b1;
    tick();
    check("t6_rst_pulse", 32'(pulse), 32'h0);
    check("t6_rst_err", 32'(cfg_err), 32'h0);
    check("t6_rst_sq", 32'(sq_out_w), 32'h0);
    tick();
    rst = 1'b0;
    rel = 0;
    run_to(4);  check("t6_after_c4", 32'(pulse), 32'h0);
    run_to(10); check("t6_after_c10", 32'(pulse), 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic bit sq_enabled();
`ifdef PULSE_GEN_SQUARE_OUT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

endmodule
